// File: rtl/sum_tx_sequencer_if.sv
// UART transmit handshake between the sum sequencer (master) and the transmitter (slave).
// Latency: none (wires only).
// Backpressure: the slave holds uart_tx_busy high while a byte is in flight.
interface sum_tx_sequencer_if;
    logic       uart_tx_en;
    logic [7:0] uart_tx_data;
    logic       uart_tx_busy;

    modport master (output uart_tx_en, output uart_tx_data, input uart_tx_busy);
    modport slave  (input uart_tx_en, input uart_tx_data, output uart_tx_busy);
endinterface

// File: rtl/sum_tx_sequencer.sv
// Debounced operand capture; each B press sends A+B as ASCII hex (+ optional CR LF) over UART.
// Latency: B press to first uart_tx_en is SYNC_STAGES + DEBOUNCE_CYCLES + 3 cycles.
// Backpressure: waits on uart_tx_busy per byte; a missing busy acknowledge aborts the frame.
module sum_tx_sequencer #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int ACK_TIMEOUT     = 32,
    parameter int SEND_CRLF       = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               save_a_n,
    input  logic               save_b_n,
    input  logic [3:0]         data_input,
    sum_tx_sequencer_if.master tx,
    output logic [3:0]         op_a,
    output logic [3:0]         op_b,
    output logic [4:0]         sum,
    output logic               seq_busy,
    output logic               tx_error
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TMR_W = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(ACK_TIMEOUT - 1);
    localparam logic [1:0]       LAST_IDX = (SEND_CRLF != 0) ? 2'd3 : 2'd1;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_LOAD      = 3'd1;
    localparam logic [2:0] S_REQ       = 3'd2;
    localparam logic [2:0] S_WAIT_ACK  = 3'd3;
    localparam logic [2:0] S_WAIT_DONE = 3'd4;

    logic [SYNC_STAGES-1:0] r_sync_a;
    logic [SYNC_STAGES-1:0] r_sync_b;
    logic [3:0]             r_sync_d [SYNC_STAGES];
    logic [1:0]             w_btn_low;
    logic [CNT_W-1:0]       r_db_cnt [2];
    logic [1:0]             r_db_pressed;
    logic [1:0]             r_db_stb;
    logic [3:0]             r_op_a;
    logic [3:0]             r_op_b;
    logic                   r_pending;
    logic [2:0]             r_state;
    logic [1:0]             r_idx;
    logic [4:0]             r_frame_sum;
    logic [TMR_W-1:0]       r_timer;
    logic [7:0]             r_tx_data;
    logic                   r_tx_error;
    logic [7:0]             w_hex_lo;
    logic [7:0]             w_byte;
    logic                   w_tx_en;

    // Button synchronizers reset to the released level so reset never looks like a press.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync_a <= '1;
            r_sync_b <= '1;
            for (int i = 0; i < SYNC_STAGES; i++) r_sync_d[i] <= 4'h0;
        end else begin
            r_sync_a[0] <= save_a_n;
            r_sync_b[0] <= save_b_n;
            r_sync_d[0] <= data_input;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync_a[i] <= r_sync_a[i-1];
                r_sync_b[i] <= r_sync_b[i-1];
                r_sync_d[i] <= r_sync_d[i-1];
            end
        end
    end

    assign w_btn_low = {~r_sync_b[SYNC_STAGES-1], ~r_sync_a[SYNC_STAGES-1]};

    // Counter runs while the synced level disagrees with the debounced state; a full run flips it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_db_pressed <= 2'b00;
            r_db_stb     <= 2'b00;
            for (int k = 0; k < 2; k++) r_db_cnt[k] <= '0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                r_db_stb[k] <= 1'b0;
                if (r_db_pressed[k] == w_btn_low[k]) begin
                    r_db_cnt[k] <= '0;
                end else if (r_db_cnt[k] == DB_LAST) begin
                    r_db_cnt[k]     <= '0;
                    r_db_pressed[k] <= w_btn_low[k];
                    r_db_stb[k]     <= w_btn_low[k];
                end else begin
                    r_db_cnt[k] <= r_db_cnt[k] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_op_a <= 4'h0;
            r_op_b <= 4'h0;
        end else begin
            if (r_db_stb[0]) r_op_a <= r_sync_d[SYNC_STAGES-1];
            if (r_db_stb[1]) r_op_b <= r_sync_d[SYNC_STAGES-1];
        end
    end

    assign sum = {1'b0, r_op_a} + {1'b0, r_op_b};

    always_comb begin
        w_hex_lo = (r_frame_sum[3:0] < 4'd10) ? (8'h30 + {4'h0, r_frame_sum[3:0]})
                                              : (8'h37 + {4'h0, r_frame_sum[3:0]});
        case (r_idx)
            2'd0:    w_byte = {7'b0011000, r_frame_sum[4]};
            2'd1:    w_byte = w_hex_lo;
            2'd2:    w_byte = 8'h0D;
            default: w_byte = 8'h0A;
        endcase
    end

    // Strobe is combinational in REQ so the first byte leaves 3 cycles after the B strobe.
    assign w_tx_en = (r_state == S_REQ) && !tx.uart_tx_busy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_pending   <= 1'b0;
            r_idx       <= 2'd0;
            r_frame_sum <= 5'd0;
            r_timer     <= '0;
            r_tx_data   <= 8'h00;
            r_tx_error  <= 1'b0;
        end else begin
            // A fresh B strobe wins over the IDLE consume, so it always yields one more frame.
            if (r_db_stb[1]) r_pending <= 1'b1;
            else if (r_state == S_IDLE && r_pending) r_pending <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (r_pending) begin
                        r_frame_sum <= sum;
                        r_idx       <= 2'd0;
                        r_state     <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_tx_data <= w_byte;
                    r_state   <= S_REQ;
                end
                S_REQ: begin
                    if (!tx.uart_tx_busy) begin
                        r_timer <= '0;
                        r_state <= S_WAIT_ACK;
                    end
                end
                S_WAIT_ACK: begin
                    if (tx.uart_tx_busy) begin
                        r_state <= S_WAIT_DONE;
                    end else if (r_timer == TMR_LAST) begin
                        r_tx_error <= 1'b1;
                        r_state    <= S_IDLE;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                S_WAIT_DONE: begin
                    if (!tx.uart_tx_busy) begin
                        if (r_idx == LAST_IDX) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_idx   <= r_idx + 2'd1;
                            r_state <= S_LOAD;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign tx.uart_tx_en   = w_tx_en;
    assign tx.uart_tx_data = r_tx_data;
    assign op_a            = r_op_a;
    assign op_b            = r_op_b;
    assign seq_busy        = (r_state != S_IDLE);
    assign tx_error        = r_tx_error;
endmodule

// File: tb/tb_sum_tx_sequencer.sv
// Directed bench: two sequencers (CR LF on / off) driven by buttons, each with a UART busy model.
module tb_sum_tx_sequencer;
    logic       clk = 1'b0;
    logic       reset;
    logic       save_a_n, save_b_n, save_b2_n;
    logic [3:0] data_in;
    logic [3:0] op_a1, op_b1, op_a2, op_b2;
    logic [4:0] sum1, sum2;
    logic       seq_busy1, tx_error1, seq_busy2, tx_error2;

    int         n_tests = 0;
    int         n_fail  = 0;
    int         busy_len = 10;
    logic       no_ack = 1'b0;
    logic       busy1 = 1'b0, busy2 = 1'b0;
    int         cnt1 = 0, cnt2 = 0;
    logic [7:0] held1 = 8'h00, held2 = 8'h00;
    int         viol1 = 0, viol2 = 0;
    logic [7:0] log1[$];
    logic [7:0] log2[$];
    int         lat;

    sum_tx_sequencer_if ifc1();
    sum_tx_sequencer_if ifc2();

    sum_tx_sequencer #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(16), .ACK_TIMEOUT(32), .SEND_CRLF(1)) dut1 (
        .clk(clk), .reset(reset), .save_a_n(save_a_n), .save_b_n(save_b_n),
        .data_input(data_in), .tx(ifc1.master), .op_a(op_a1), .op_b(op_b1),
        .sum(sum1), .seq_busy(seq_busy1), .tx_error(tx_error1));

    sum_tx_sequencer #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(16), .ACK_TIMEOUT(32), .SEND_CRLF(0)) dut2 (
        .clk(clk), .reset(reset), .save_a_n(save_a_n), .save_b_n(save_b2_n),
        .data_input(data_in), .tx(ifc2.master), .op_a(op_a2), .op_b(op_b2),
        .sum(sum2), .seq_busy(seq_busy2), .tx_error(tx_error2));

    assign ifc1.uart_tx_busy = busy1;
    assign ifc2.uart_tx_busy = busy2;

    always #5 clk = ~clk;

    // UART models: log each strobed byte, hold busy for busy_len cycles, flag protocol breaks.
    always @(posedge clk) begin
        if (reset) begin
            busy1 <= 1'b0;
            cnt1  <= 0;
        end else if (ifc1.uart_tx_en) begin
            if (busy1) viol1++;
            log1.push_back(ifc1.uart_tx_data);
            if (!no_ack) begin
                held1 <= ifc1.uart_tx_data;
                busy1 <= 1'b1;
                cnt1  <= busy_len;
            end
        end else if (busy1) begin
            if (ifc1.uart_tx_data !== held1) viol1++;
            if (cnt1 <= 1) busy1 <= 1'b0;
            else cnt1 <= cnt1 - 1;
        end
    end

    always @(posedge clk) begin
        if (reset) begin
            busy2 <= 1'b0;
            cnt2  <= 0;
        end else if (ifc2.uart_tx_en) begin
            if (busy2) viol2++;
            log2.push_back(ifc2.uart_tx_data);
            if (!no_ack) begin
                held2 <= ifc2.uart_tx_data;
                busy2 <= 1'b1;
                cnt2  <= busy_len;
            end
        end else if (busy2) begin
            if (ifc2.uart_tx_data !== held2) viol2++;
            if (cnt2 <= 1) busy2 <= 1'b0;
            else cnt2 <= cnt2 - 1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_btn(input int b, input logic v);
        case (b)
            0:       save_a_n  = v;
            1:       save_b_n  = v;
            default: save_b2_n = v;
        endcase
    endtask

    task automatic press(input int b);
        set_btn(b, 1'b0);
        tick(22);
        set_btn(b, 1'b1);
        tick(20);
    endtask

    task automatic wait_idle(input int d, input string tag);
        int quiet = 0;
        for (int i = 0; i < 3000 && quiet < 5; i++) begin
            tick(1);
            if ((d == 1) ? seq_busy1 : seq_busy2) quiet = 0;
            else quiet++;
        end
        check_eq({tag, "_idle"}, quiet >= 5, 1);
    endtask

    task automatic check_frame(input string tag, input int base,
                               input logic [7:0] b0, input logic [7:0] b1,
                               input logic [7:0] b2, input logic [7:0] b3);
        logic [7:0] e [4];
        e[0] = b0; e[1] = b1; e[2] = b2; e[3] = b3;
        for (int i = 0; i < 4; i++) begin
            if (base + i < log1.size()) check_eq($sformatf("%s_b%0d", tag, i), log1[base+i], e[i]);
            else check_eq($sformatf("%s_b%0d_missing", tag, i), 0, 1);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check_eq({tag, "_en"},    ifc1.uart_tx_en, 0);
        check_eq({tag, "_data"},  ifc1.uart_tx_data, 0);
        check_eq({tag, "_opa"},   op_a1, 0);
        check_eq({tag, "_opb"},   op_b1, 0);
        check_eq({tag, "_sum"},   sum1, 0);
        check_eq({tag, "_busy"},  seq_busy1, 0);
        check_eq({tag, "_err"},   tx_error1, 0);
    endtask

    initial begin
        reset = 1'b1; save_a_n = 1'b1; save_b_n = 1'b1; save_b2_n = 1'b1; data_in = 4'h0;
        tick(3);
        check_zero_outputs("rst");
        reset = 1'b0;
        tick(3);
        check_zero_outputs("post_rst");

        // 5 + 9 = 14: "0E\r\n", plus first-strobe latency
        data_in = 4'h5; tick(5); press(0);
        data_in = 4'h9; tick(5);
        log1.delete();
        set_btn(1, 1'b0);
        lat = 0;
        for (int i = 0; i < 100; i++) begin
            tick(1);
            lat++;
            if (ifc1.uart_tx_en) break;
        end
        check_eq("latency", lat, 21);
        tick(2); set_btn(1, 1'b1); tick(20);
        wait_idle(1, "t1");
        check_eq("t1_opa", op_a1, 4'h5);
        check_eq("t1_opb", op_b1, 4'h9);
        check_eq("t1_sum", sum1, 5'd14);
        check_eq("t1_nbytes", log1.size(), 4);
        check_frame("t1", 0, 8'h30, 8'h45, 8'h0D, 8'h0A);

        // F + F = 0x1E with bouncing B button: one frame "1E\r\n"
        data_in = 4'hF; tick(5); press(0); tick(5);
        log1.delete();
        for (int i = 0; i < 3; i++) begin
            set_btn(1, 1'b0); tick(1);
            set_btn(1, 1'b1); tick(1);
        end
        press(1);
        wait_idle(1, "t2");
        check_eq("t2_sum", sum1, 5'h1E);
        check_eq("t2_nbytes", log1.size(), 4);
        check_frame("t2", 0, 8'h31, 8'h45, 8'h0D, 8'h0A);

        // Re-press during byte 2, then again: exactly one extra frame with F + 1 = 0x10
        busy_len = 40;
        log1.delete();
        press(1);
        data_in = 4'h1;
        for (int i = 0; i < 500 && log1.size() < 2; i++) tick(1);
        check_eq("t3_reach_byte2", log1.size(), 2);
        press(1);
        press(1);
        wait_idle(1, "t3");
        check_eq("t3_nbytes", log1.size(), 8);
        check_frame("t3_f1", 0, 8'h31, 8'h45, 8'h0D, 8'h0A);
        check_frame("t3_f2", 4, 8'h31, 8'h30, 8'h0D, 8'h0A);
        check_eq("t3_err", tx_error1, 0);

        // No busy acknowledge: sticky error, frame dropped, next frame still sent
        busy_len = 10; no_ack = 1'b1; data_in = 4'h2;
        log1.delete();
        press(1);
        wait_idle(1, "t4");
        check_eq("t4_err", tx_error1, 1);
        check_eq("t4_busy", seq_busy1, 0);
        check_eq("t4_nbytes", log1.size(), 1);
        no_ack = 1'b0; data_in = 4'h3;
        log1.delete();
        press(1);
        wait_idle(1, "t4b");
        check_eq("t4b_nbytes", log1.size(), 4);
        check_frame("t4b", 0, 8'h31, 8'h32, 8'h0D, 8'h0A);
        check_eq("t4b_err_sticky", tx_error1, 1);

        // Reset while waiting for busy to fall
        busy_len = 40; data_in = 4'h4;
        press(1);
        check_eq("t5_pre_busy", seq_busy1, 1);
        check_eq("t5_pre_uart_busy", busy1, 1);
        reset = 1'b1;
        tick(1);
        check_zero_outputs("t5_rst");
        tick(1);
        reset = 1'b0;
        log1.delete();
        tick(100);
        check_eq("t5_no_tx", log1.size(), 0);
        check_eq("t5_idle", seq_busy1, 0);
        busy_len = 10;
        press(1);
        wait_idle(1, "t5b");
        check_eq("t5b_opa", op_a1, 4'h0);
        check_eq("t5b_opb", op_b1, 4'h4);
        check_eq("t5b_sum", sum1, 5'd4);
        check_eq("t5b_nbytes", log1.size(), 4);
        check_frame("t5b", 0, 8'h30, 8'h34, 8'h0D, 8'h0A);

        // No CR LF variant: 0 + 0 -> "00", seq_busy drops right after second busy fall
        busy_len = 30; data_in = 4'h0; tick(5);
        log2.delete();
        press(0);
        press(2);
        for (int i = 0; i < 500 && log2.size() < 2; i++) tick(1);
        check_eq("t6_reach_byte2", log2.size(), 2);
        for (int i = 0; i < 500 && busy2; i++) tick(1);
        check_eq("t6_busy_fell", busy2, 0);
        check_eq("t6_seq_busy_before", seq_busy2, 1);
        tick(1);
        check_eq("t6_seq_busy_after", seq_busy2, 0);
        wait_idle(2, "t6");
        check_eq("t6_nbytes", log2.size(), 2);
        if (log2.size() >= 2) begin
            check_eq("t6_b0", log2[0], 8'h30);
            check_eq("t6_b1", log2[1], 8'h30);
        end

        check_eq("proto1", viol1, 0);
        check_eq("proto2", viol2, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
